// File: rtl/sram_sync.sv
// Parameterised single-clock synchronous SRAM: per-byte write enables, ready/valid
// request handshake, RD_LAT-deep read pipeline and a full-array clear engine.

module sram_sync_lane #(
  parameter int          AW       = 8,
  parameter int          RD_LAT   = 1,
  parameter logic [7:0]  CLR_BYTE = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clearing,
  input  logic [AW-1:0]     clr_addr,
  input  logic              wen,
  input  logic [AW-1:0]     addr,
  input  logic [7:0]        wdata,
  input  logic [RD_LAT-1:0] ld,
  output logic [7:0]        rdata
);
  localparam int DEPTH = 2**AW;

  logic [7:0] mem [DEPTH];
  logic [RD_LAT:1][7:0] pipe;

  // Storage carries no reset; the clear engine owns initialisation.
  always_ff @(posedge clk) begin
    if (clearing)  mem[clr_addr] <= CLR_BYTE;
    else if (wen)  mem[addr]     <= wdata;
  end

  // Stage 1 captures the array at accept time, so later clear writes never
  // disturb a read already in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= '0;
    end else begin
      if (ld[0]) pipe[1] <= mem[addr];
      for (int k = 2; k <= RD_LAT; k++)
        if (ld[k-1]) pipe[k] <= pipe[k-1];
    end
  end

  assign rdata = pipe[RD_LAT];
endmodule

module sram_sync #(
  parameter int              DW      = 16,
  parameter int              AW      = 8,
  parameter int              RD_LAT  = 1,
  parameter logic [DW-1:0]   CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              we,
  input  logic [DW/8-1:0]   be,
  input  logic [AW-1:0]     addr,
  input  logic [DW-1:0]     din,
  input  logic              clr,
  output logic              ready,
  output logic [DW-1:0]     dout,
  output logic              dvalid
);
  localparam int NUM_LANES = DW / 8;
  localparam int DEPTH     = 2**AW;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            acc, wr, rd, clearing;
  logic [RD_LAT:1] vld_q;
  logic [RD_LAT:0] vld_pipe;

  assign ready    = (state_q == IDLE) && !clr;
  assign acc      = cs && ready;
  assign wr       = acc && we;
  assign rd       = acc && !we;
  assign clearing = (state_q == CLEAR);
  assign vld_pipe = {vld_q, rd};
  assign dvalid   = vld_pipe[RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_pipe[RD_LAT-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) state_d = IDLE;
      end
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    sram_sync_lane #(
      .AW      (AW),
      .RD_LAT  (RD_LAT),
      .CLR_BYTE(CLR_VAL[8*i +: 8])
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .clearing(clearing),
      .clr_addr(cnt_q),
      .wen     (wr && be[i]),
      .addr    (addr),
      .wdata   (din[8*i +: 8]),
      .ld      (vld_pipe[RD_LAT-1:0]),
      .rdata   (dout[8*i +: 8])
    );
  end
endmodule

// File: tb/tb_sram_sync.sv
// Directed bench: two sram_sync instances (RD_LAT=1 and RD_LAT=2) driven by the
// same stimulus, each checked against hand-computed expected values.

module tb_sram_sync;
  logic        clk, rst_n, cs, we, clr;
  logic [1:0]  be;
  logic [3:0]  addr;
  logic [15:0] din;
  logic        r1, v1, r2, v2;
  logic [15:0] d1, d2;

  int n_chk  = 0;
  int n_fail = 0;

  sram_sync #(.DW(16), .AW(4), .RD_LAT(1), .CLR_VAL(16'hA5A5)) u_l1 (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .be(be), .addr(addr),
    .din(din), .clr(clr), .ready(r1), .dout(d1), .dvalid(v1));

  sram_sync #(.DW(16), .AW(4), .RD_LAT(2), .CLR_VAL(16'hA5A5)) u_l2 (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .be(be), .addr(addr),
    .din(din), .clr(clr), .ready(r2), .dout(d2), .dvalid(v2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] b);
    cs = 1'b1; we = 1'b1; addr = a; din = d; be = b;
    tick();
    cs = 1'b0; we = 1'b0;
  endtask

  // Read accepted at edge N: L1 valid after N, L2 valid after N+1.
  task automatic rd(input string tag, input logic [3:0] a, input logic [15:0] exp);
    cs = 1'b1; we = 1'b0; addr = a;
    tick();
    cs = 1'b0;
    chk({tag, " l1 dvalid"}, 32'(v1), 32'd1);
    chk({tag, " l1 dout"},   32'(d1), 32'(exp));
    chk({tag, " l2 early"},  32'(v2), 32'd0);
    tick();
    chk({tag, " l1 drop"},   32'(v1), 32'd0);
    chk({tag, " l2 dvalid"}, 32'(v2), 32'd1);
    chk({tag, " l2 dout"},   32'(d2), 32'(exp));
  endtask

  // Expects ready low for n more cycles, then high.
  task automatic clear_wait(input string tag, input int n);
    for (int j = 0; j < n; j++) begin
      chk($sformatf("%s busy l1 c%0d", tag, j), 32'(r1), 32'd0);
      chk($sformatf("%s busy l2 c%0d", tag, j), 32'(r2), 32'd0);
      tick();
    end
    chk({tag, " done l1"}, 32'(r1), 32'd1);
    chk({tag, " done l2"}, 32'(r2), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; cs = 1'b0; we = 1'b0; clr = 1'b0;
    be = 2'b00; addr = '0; din = '0;
    tick(); tick();
    chk("rst dout l1", 32'(d1), 32'd0);
    chk("rst dout l2", 32'(d2), 32'd0);
    chk("rst dvalid l1", 32'(v1), 32'd0);
    chk("rst dvalid l2", 32'(v2), 32'd0);
    chk("rst ready l1", 32'(r1), 32'd0);
    rst_n = 1'b1;
    clear_wait("initclr", 16);
    chk("pre-read dout l1", 32'(d1), 32'd0);
    chk("pre-read dout l2", 32'(d2), 32'd0);
    for (int k = 0; k < 16; k++) rd($sformatf("init a%0d", k), 4'(k), 16'hA5A5);

    // Byte enables
    wr(4'd3, 16'h1234, 2'b11);
    rd("be11", 4'd3, 16'h1234);
    wr(4'd3, 16'hFF00, 2'b01);
    rd("be01", 4'd3, 16'h1200);
    wr(4'd3, 16'hFFFF, 2'b00);
    rd("be00", 4'd3, 16'h1200);

    // Back-to-back reads, descending addresses
    for (int k = 0; k < 16; k++) wr(4'(k), 16'(16'h0100 + k), 2'b11);
    for (int i = 0; i < 18; i++) begin
      if (i < 16) begin cs = 1'b1; we = 1'b0; addr = 4'(15 - i); end
      else cs = 1'b0;
      tick();
      chk($sformatf("b2b l1 dv %0d", i), 32'(v1), 32'(i < 16));
      if (i < 16) chk($sformatf("b2b l1 d %0d", i), 32'(d1), 32'(16'h010F - i));
      chk($sformatf("b2b l2 dv %0d", i), 32'(v2), 32'(i >= 1 && i <= 16));
      if (i >= 1 && i <= 16) chk($sformatf("b2b l2 d %0d", i), 32'(d2), 32'(16'h010F - (i - 1)));
    end
    cs = 1'b0;

    // Write then read next cycle
    wr(4'd7, 16'hBEEF, 2'b11);
    rd("wtr a7", 4'd7, 16'hBEEF);

    // Read accepted one cycle before clr: returns pre-clear data
    cs = 1'b1; we = 1'b0; addr = 4'd2;
    tick();
    cs = 1'b0; clr = 1'b1;
    #1;
    chk("pre-clr ready l1", 32'(r1), 32'd0);
    chk("pre-clr l1 dv", 32'(v1), 32'd1);
    chk("pre-clr l1 d", 32'(d1), 32'h0102);
    tick();
    clr = 1'b0;
    chk("pre-clr l2 dv", 32'(v2), 32'd1);
    chk("pre-clr l2 d", 32'(d2), 32'h0102);
    chk("pre-clr l1 drop", 32'(v1), 32'd0);
    clear_wait("reqclr1", 16);
    rd("postclr a2", 4'd2, 16'hA5A5);
    rd("postclr a7", 4'd7, 16'hA5A5);

    // Read in the same cycle clr rises: not accepted
    wr(4'd2, 16'h0102, 2'b11);
    rd("reload a2", 4'd2, 16'h0102);
    cs = 1'b1; we = 1'b0; addr = 4'd2; clr = 1'b1;
    #1;
    chk("same-clr ready l1", 32'(r1), 32'd0);
    chk("same-clr ready l2", 32'(r2), 32'd0);
    tick();
    cs = 1'b0; clr = 1'b0;
    chk("same-clr l1 dv0", 32'(v1), 32'd0);
    chk("same-clr l2 dv0", 32'(v2), 32'd0);
    tick();
    chk("same-clr l1 dv1", 32'(v1), 32'd0);
    chk("same-clr l2 dv1", 32'(v2), 32'd0);
    clear_wait("reqclr2", 15);
    chk("same-clr hold l1", 32'(d1), 32'h0102);
    chk("same-clr hold l2", 32'(d2), 32'h0102);
    rd("postclr2 a2", 4'd2, 16'hA5A5);

    // Reset five cycles into a clear
    for (int k = 0; k < 16; k++) wr(4'(k), 16'(16'h0200 + k), 2'b11);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst dout l1", 32'(d1), 32'd0);
    chk("midrst dout l2", 32'(d2), 32'd0);
    chk("midrst dv l1", 32'(v1), 32'd0);
    chk("midrst dv l2", 32'(v2), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    clear_wait("rstclr", 16);
    for (int k = 0; k < 16; k++) rd($sformatf("final a%0d", k), 4'(k), 16'hA5A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
